// File: rtl/d_branch_resolve_pkg.sv
// Shared D-stage branch header: compare-flag bit positions, branch type codes,
// redirect FSM states and the taken-decision helper.
package d_branch_resolve_pkg;

  localparam int unsigned A_LARGER_THAN_0 = 0;
  localparam int unsigned A_EQUAL_0       = 1;
  localparam int unsigned B_LARGER_THAN_0 = 2;
  localparam int unsigned B_EQUAL_0       = 3;
  localparam int unsigned A_LARGER_THAN_B = 4;
  localparam int unsigned A_EQUAL_B       = 5;
  localparam int unsigned A_LESS_THAN_B   = 6;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLEZ = 4'd3,
    BR_BGTZ = 4'd4,
    BR_BLTZ = 4'd5,
    BR_BGEZ = 4'd6,
    BR_J    = 4'd7,
    BR_JAL  = 4'd8,
    BR_JR   = 4'd9,
    BR_JALR = 4'd10
  } br_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  // Unknown encodings fall into default and behave like BR_NONE.
  function automatic logic br_known(input logic [3:0] t);
    logic k;
    case (t)
      BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ,
      BR_J, BR_JAL, BR_JR, BR_JALR: k = 1'b1;
      default:                      k = 1'b0;
    endcase
    return k;
  endfunction

  function automatic logic br_taken(input logic [3:0] t, input logic a_eq_b,
                                    input logic a_gt0, input logic a_eq0);
    logic tk;
    case (t)
      BR_BEQ:                         tk = a_eq_b;
      BR_BNE:                         tk = ~a_eq_b;
      BR_BLEZ:                        tk = ~a_gt0;
      BR_BGTZ:                        tk = a_gt0;
      BR_BLTZ:                        tk = ~a_gt0 & ~a_eq0;
      BR_BGEZ:                        tk = a_gt0 | a_eq0;
      BR_J, BR_JAL, BR_JR, BR_JALR:   tk = 1'b1;
      default:                        tk = 1'b0;
    endcase
    return tk;
  endfunction

endpackage

// File: rtl/d_branch_resolve_target.sv
// Combinational branch/jump target and link-address calculator for the D stage.
module d_branch_target
  import d_branch_resolve_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic [3:0]      br_type,
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm16,
  input  logic [25:0]     index26,
  input  logic [PC_W-1:0] rs_val,
  output logic [PC_W-1:0] target,
  output logic [PC_W-1:0] link
);

  logic [PC_W-1:0] pc4;
  logic [PC_W-1:0] boff;

  always_comb begin
    pc4  = pc + PC_W'(4);
    boff = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
    link = '0;
    case (br_type)
      BR_J:    target = {pc4[PC_W-1:28], index26, 2'b00};
      BR_JAL: begin
        target = {pc4[PC_W-1:28], index26, 2'b00};
        link   = pc + PC_W'(8);
      end
      BR_JR:   target = rs_val;
      BR_JALR: begin
        target = rs_val;
        link   = pc + PC_W'(8);
      end
      default: target = pc4 + boff;
    endcase
  end

endmodule

// File: rtl/d_branch_resolve.sv
// D-stage branch resolve and registered redirect handshake toward F.
// Optional BR_ALIGN_CHECK_EN adds out_adel for misaligned JR/JALR targets.
module d_branch_resolve
  import d_branch_resolve_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h00003000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            in_stall,
  input  logic [3:0]      in_br_type,
  input  logic [7:0]      in_cmpresult,
  input  logic [PC_W-1:0] in_pc,
  input  logic [15:0]     in_imm16,
  input  logic [25:0]     in_index26,
  input  logic [PC_W-1:0] in_rs_val,
  input  logic            in_f_ready,
  output logic            out_redirect,
  output logic [PC_W-1:0] out_target_pc,
  output logic [PC_W-1:0] out_link_pc,
`ifdef BR_ALIGN_CHECK_EN
  output logic            out_adel,
`endif
  output logic            out_hold
);

  state_e          state;
  logic            resolve;
  logic            taken;
  logic            redirect_ok;
  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] link;
  logic            unused_flags;

  assign unused_flags = ^{in_cmpresult[7], in_cmpresult[A_LESS_THAN_B],
                          in_cmpresult[A_LARGER_THAN_B], in_cmpresult[B_EQUAL_0],
                          in_cmpresult[B_LARGER_THAN_0]};

  d_branch_target #(.PC_W(PC_W)) u_target (
    .br_type (in_br_type),
    .pc      (in_pc),
    .imm16   (in_imm16),
    .index26 (in_index26),
    .rs_val  (in_rs_val),
    .target  (tgt),
    .link    (link)
  );

  // A resolve presented while PEND is masked; D re-presents it once we are IDLE.
  assign out_hold = (state == PEND);
  assign resolve  = in_valid & ~in_stall & ~out_hold & br_known(in_br_type);
  assign taken    = br_taken(in_br_type, in_cmpresult[A_EQUAL_B],
                             in_cmpresult[A_LARGER_THAN_0], in_cmpresult[A_EQUAL_0]);

`ifdef BR_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned  = ((in_br_type == BR_JR) || (in_br_type == BR_JALR)) &&
                       (in_rs_val[1:0] != 2'b00);
  assign redirect_ok = taken & ~misaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_adel <= 1'b0;
    else       out_adel <= resolve & misaligned;
  end
`else
  assign redirect_ok = taken;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      out_redirect  <= 1'b0;
      out_target_pc <= RESET_PC;
      out_link_pc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (resolve) begin
            out_link_pc <= link;
            if (redirect_ok) begin
              state         <= PEND;
              out_redirect  <= 1'b1;
              out_target_pc <= tgt;
            end
          end
        end
        PEND: begin
          if (in_f_ready) begin
            state        <= IDLE;
            out_redirect <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_branch_resolve.sv
// Scoreboard bench for d_branch_resolve: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_d_branch_resolve;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_stall, in_f_ready;
  logic [3:0]  in_br_type;
  logic [7:0]  in_cmpresult;
  logic [31:0] in_pc, in_rs_val;
  logic [15:0] in_imm16;
  logic [25:0] in_index26;
  logic        out_redirect, out_hold;
  logic [31:0] out_target_pc, out_link_pc;
`ifdef BR_ALIGN_CHECK_EN
  logic        out_adel;
`endif

  typedef struct {
    string       tag;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] link;
    logic        hold;
    logic        adel;
  } exp_t;

  exp_t sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  d_branch_resolve #(.PC_W(32), .RESET_PC(32'h00003000)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_stall      (in_stall),
    .in_br_type    (in_br_type),
    .in_cmpresult  (in_cmpresult),
    .in_pc         (in_pc),
    .in_imm16      (in_imm16),
    .in_index26    (in_index26),
    .in_rs_val     (in_rs_val),
    .in_f_ready    (in_f_ready),
    .out_redirect  (out_redirect),
    .out_target_pc (out_target_pc),
    .out_link_pc   (out_link_pc),
`ifdef BR_ALIGN_CHECK_EN
    .out_adel      (out_adel),
`endif
    .out_hold      (out_hold)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".redirect"}, 32'(out_redirect), 32'(e.redirect));
      chk({e.tag, ".target"},   out_target_pc,     e.target);
      chk({e.tag, ".link"},     out_link_pc,       e.link);
      chk({e.tag, ".hold"},     32'(out_hold),     32'(e.hold));
`ifdef BR_ALIGN_CHECK_EN
      chk({e.tag, ".adel"},     32'(out_adel),     32'(e.adel));
`endif
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] t,
                       input logic [7:0] c, input logic [31:0] pc,
                       input logic [15:0] imm, input logic [25:0] idx,
                       input logic [31:0] rs, input logic fr);
    in_valid = v; in_stall = s; in_br_type = t; in_cmpresult = c;
    in_pc = pc; in_imm16 = imm; in_index26 = idx; in_rs_val = rs; in_f_ready = fr;
  endtask

  task automatic idle(input logic fr);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 32'h0, 16'h0, 26'h0, 32'h0, fr);
  endtask

  task automatic expect_out(input string tag, input logic r, input logic [31:0] t,
                            input logic [31:0] l, input logic h, input logic a = 1'b0);
    exp_t e;
    e.tag = tag; e.redirect = r; e.target = t; e.link = l; e.hold = h; e.adel = a;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    idle(1'b0);
    next_cycle();
    expect_out("reset", 0, 32'h3000, 0, 0);

    next_cycle(); reset = 1'b0;
    drive(1, 0, 4'd1, 8'h20, 32'h3000, 16'h0004, 26'h0, 32'h0, 1);  // BEQ taken
    expect_out("beq_pre", 0, 32'h3000, 0, 0);
    next_cycle(); idle(1);
    expect_out("beq_redir", 1, 32'h3014, 0, 1);
    next_cycle(); idle(0);
    expect_out("beq_clear", 0, 32'h3014, 0, 0);

    next_cycle();
    drive(1, 0, 4'd2, 8'h20, 32'h3100, 16'h0004, 26'h0, 32'h0, 0);  // BNE untaken
    expect_out("bne_pre", 0, 32'h3014, 0, 0);
    next_cycle(); idle(0);
    expect_out("bne_none", 0, 32'h3014, 0, 0);

    next_cycle();
    drive(1, 0, 4'd8, 8'h00, 32'h3008, 16'h0, 26'h0000C00, 32'h0, 0);  // JAL
    expect_out("jal_pre", 0, 32'h3014, 0, 0);
    next_cycle(); idle(0);
    expect_out("jal_h1", 1, 32'h3000, 32'h3010, 1);
    next_cycle();
    drive(1, 0, 4'd1, 8'h20, 32'h4000, 16'h0010, 26'h0, 32'h0, 0);  // masked by hold
    expect_out("jal_h2", 1, 32'h3000, 32'h3010, 1);
    next_cycle(); idle(0);
    expect_out("jal_h3", 1, 32'h3000, 32'h3010, 1);
    next_cycle(); idle(1);
    expect_out("jal_h4", 1, 32'h3000, 32'h3010, 1);
    next_cycle(); idle(0);
    expect_out("jal_clear", 0, 32'h3000, 32'h3010, 0);

    next_cycle();
    drive(1, 1, 4'd4, 8'h01, 32'h3200, 16'h0010, 26'h0, 32'h0, 0);  // BGTZ stalled
    expect_out("bgtz_st1", 0, 32'h3000, 32'h3010, 0);
    next_cycle();
    drive(1, 1, 4'd4, 8'h01, 32'h3200, 16'h0010, 26'h0, 32'h0, 0);
    expect_out("bgtz_st2", 0, 32'h3000, 32'h3010, 0);
    next_cycle();
    drive(1, 0, 4'd4, 8'h01, 32'h3200, 16'h0010, 26'h0, 32'h0, 0);
    expect_out("bgtz_st3", 0, 32'h3000, 32'h3010, 0);
    next_cycle(); idle(1);
    expect_out("bgtz_redir", 1, 32'h3244, 0, 1);
    next_cycle(); idle(0);
    expect_out("bgtz_clear", 0, 32'h3244, 0, 0);

    next_cycle();
    drive(1, 0, 4'd5, 8'h00, 32'h3000, 16'h8000, 26'h0, 32'h0, 0);  // BLTZ wrap
    expect_out("bltz_pre", 0, 32'h3244, 0, 0);
    next_cycle(); idle(0);
    expect_out("bltz_wrap", 1, 32'hFFFE3004, 0, 1);

    next_cycle(); idle(0); reset = 1'b1;  // asynchronous reset while PEND
    expect_out("rst_pend", 0, 32'h3000, 0, 0);
    next_cycle(); reset = 1'b0; idle(1);  // f_ready in IDLE ignored
    expect_out("rst_after", 0, 32'h3000, 0, 0);

    next_cycle();
    drive(1, 0, 4'd1, 8'h80, 32'h3000, 16'h0004, 26'h0, 32'h0, 1);  // bit7 ignored
    expect_out("idle_fr", 0, 32'h3000, 0, 0);
    next_cycle();
    drive(1, 0, 4'hF, 8'hFF, 32'h3000, 16'h0004, 26'h0, 32'h0, 1);  // unknown type
    expect_out("bit7", 0, 32'h3000, 0, 0);
    next_cycle();
    drive(1, 0, 4'd10, 8'h00, 32'h3020, 16'h0, 26'h0, 32'h5000, 1);  // JALR
    expect_out("unknown", 0, 32'h3000, 0, 0);
    next_cycle(); idle(1);
    expect_out("jalr_redir", 1, 32'h5000, 32'h3028, 1);
    next_cycle();
    drive(1, 0, 4'd9, 8'h00, 32'h3040, 16'h0, 26'h0, 32'h3002, 1);  // misaligned JR
    expect_out("jalr_clear", 0, 32'h5000, 32'h3028, 0);
    next_cycle(); idle(0);
`ifdef BR_ALIGN_CHECK_EN
    expect_out("jr_adel", 0, 32'h5000, 0, 0, 1);
    next_cycle(); idle(0);
    expect_out("jr_adel_end", 0, 32'h5000, 0, 0, 0);
`else
    expect_out("jr_mis", 1, 32'h3002, 0, 1);
    next_cycle(); idle(0);
    expect_out("jr_mis_hold", 1, 32'h3002, 0, 1);
`endif

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/d_branch_resolve.md
Name: d_branch_resolve

Overview:
- D-stage consumer of the 8-bit compare-result vector produced by the D-stage comparator.
- Combines the compare flags with the decoded branch/jump type and computes the branch decision and target PC.
- Registers a redirect request toward the F stage and holds it until F accepts it.
- Owns the delay-slot-aware redirect handshake between D and F in the 5-stage MIPS pipeline.

Parameters:
- PC_W, 32, PC and target width.
- RESET_PC, 32'h00003000, value loaded into out_target_pc on reset.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  D-stage instruction valid this cycle.
- in_stall  in  1  hazard unit stalling D; operands or flags not yet final.
- in_br_type  in  4  decoded type: NONE, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, J, JAL, JR, JALR.
- in_cmpresult  in  8  compare flags, bit positions per the shared header.
- in_pc  in  32  PC of the D-stage instruction.
- in_imm16  in  16  branch offset field.
- in_index26  in  26  jump index field.
- in_rs_val  in  32  forwarded rs value, used by JR/JALR.
- in_f_ready  in  1  F stage accepts a redirect this cycle.
- out_redirect  out  1  registered; redirect request pending toward F.
- out_target_pc  out  32  registered redirect target.
- out_link_pc  out  32  registered in_pc+8 for JAL/JALR; 0 otherwise.
- out_hold  out  1  combinational; forces D to stall while a redirect is unaccepted.

Behaviour:
- Reset: state IDLE, out_redirect=0, out_target_pc=RESET_PC, out_link_pc=0.
- Resolve event: in_valid & ~in_stall & ~out_hold & (in_br_type != NONE).
- Taken conditions:
  - BEQ: AEqualB. BNE: ~AEqualB.
  - BLEZ: ~ALargerThan0. BGTZ: ALargerThan0.
  - BLTZ: ~ALargerThan0 & ~AEqual0. BGEZ: ALargerThan0 | AEqual0.
  - J, JAL, JR, JALR: always taken.
- Target computation:
  - Branch: in_pc + 4 + (sign-extended imm16 << 2), mod 2^32; wrap-around is silent.
  - J/JAL: {pc4[31:28], index26, 2'b00}, where pc4 = in_pc+4.
  - JR/JALR: in_rs_val as-is; no alignment check in base configuration.
- Latency: resolve in cycle N; out_redirect/out_target_pc valid from N+1. The delay slot is fetched during N, so the redirect applies to the fetch after the delay slot.
- Untaken branch: no state change except out_link_pc.
- out_link_pc updates on every resolve event, including untaken branches.
- FSM:
  - IDLE: a taken resolve goes to PEND, with out_redirect=1 and target latched.
  - PEND: out_hold=1. On in_f_ready go to IDLE and clear out_redirect next edge; target stays as last value. Otherwise stay in PEND, with target and redirect stable.
- Simultaneous events:
  - in_f_ready in IDLE is ignored.
  - A resolve attempted in PEND is masked by out_hold; it is not lost, because D re-presents it once IDLE.
  - in_stall=1 with in_valid=1 means no resolve, even if the flags look taken.
- in_cmpresult bit7 is reserved and ignored.
- An unknown in_br_type encoding is treated as NONE.
- Reset mid-PEND: redirect dropped immediately, asynchronously; state IDLE.

Optional Feature:
- Macro: BR_ALIGN_CHECK_EN.
- Enabled:
  - Adds output out_adel (1 bit, registered).
  - If a JR/JALR target has in_rs_val[1:0] != 0, out_adel pulses for one cycle.
  - No redirect is issued; state remains IDLE.
- Disabled: port absent; misaligned targets are redirected unmodified.

Decomposition:
- The shared signal header holds:
  - compare-flag bit constants: ALargerThan0=bit0, AEqual0=bit1, BLargerThan0=bit2, BEqual0=bit3, ALargerThanB=bit4, AEqualB=bit5, ALessThanB=bit6;
  - the 4-bit br_type encodings;
  - the IDLE/PEND state codes.
- Sub-module d_branch_target: purely combinational target and link-address calculator, instantiated once.
- Taken logic and FSM stay in the top module.

Test Plan:
- BEQ, cmpresult with AEqualB set, in_pc=0x3000, imm16=0x0004, in_f_ready=1 -> next cycle out_redirect=1, target=0x3014; following cycle out_redirect=0.
- BNE, AEqualB set -> out_redirect stays 0, out_hold=0, no state change.
- JAL, in_pc=0x3008, index26=0x0000C00, in_f_ready=0 for 3 cycles then 1 -> out_redirect held 4 cycles with target=0x00003000 (pc4=0x300C), out_link_pc=0x3010, out_hold=1 throughout, then cleared.
- BGTZ, ALargerThan0 set, with in_stall=1 for 2 cycles then 0 -> no redirect during the stall; redirect one cycle after in_stall drops.
- BLTZ, in_pc=0x00003000, imm16=0x8000 -> target = 0x3004 - 0x20000 = 0xFFFE3004 (wraps).
- Assert reset during PEND -> out_redirect=0 immediately, out_target_pc=0x00003000, state IDLE.
- With BR_ALIGN_CHECK_EN: JR with rs=0x3002 -> out_adel one-cycle pulse, out_redirect=0.
